delay_skew_meas: RTL and testbench
==================================

# delay_skew_meas

Measures the fixed clock-cycle skew between two copies of a marker pulse arriving on two channels. It produces the `delay` setting for the programmable delay line on the early channel, which lines that channel up with the late one. It sits directly upstream of the delay line's `delay` input and is run once per calibration request. It accepts a result only when NUM_MEAS consecutive measurements agree.

## Interface
Parameters:
- MAX_DELAY, 15, largest skew (cycles) that can be measured; must equal the downstream delay line's MAX_DELAY
- NUM_MEAS, 4, consecutive identical measurements required before a result is published (≥1)
- DELAY_WIDTH, $clog2(MAX_DELAY+1), localparam, width of `delay`

Ports:
- clk  in  1  single clock; all logic on posedge clk
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a calibration run
- mark_early  in  1  marker pulse on the channel that will be delayed
- mark_late  in  1  marker pulse on the reference (late) channel
- delay  out  DELAY_WIDTH  measured skew, feeds the delay line's `delay` input
- valid  out  1  `delay` holds a result from the most recent successful run
- busy  out  1  run in progress
- err_timeout  out  1  sticky: skew exceeded MAX_DELAY
- err_mismatch  out  1  sticky: measurements disagreed

## Operation
- State machine states: IDLE, WAIT_EARLY, COUNT.
- IDLE:
  - busy=0.
  - start=1 → WAIT_EARLY; clear meas_cnt, err_timeout, err_mismatch and valid.
  - `delay` keeps its old value until a new result is published.
- WAIT_EARLY (busy=1):
  - mark_late alone is ignored.
  - mark_early together with mark_late → sample = 0, record.
  - mark_early alone with MAX_DELAY=0 → err_timeout, → IDLE.
  - mark_early alone otherwise → skew_cnt ← 1, → COUNT.
- COUNT (busy=1):
  - mark_early is ignored.
  - mark_late → sample = skew_cnt, record.
  - No mark_late and skew_cnt == MAX_DELAY → err_timeout, → IDLE.
  - Otherwise skew_cnt ← skew_cnt + 1.
- Record:
  - First sample of a run is stored in ref_val.
  - Later samples must equal ref_val; otherwise set err_mismatch, → IDLE.
  - meas_cnt increments on each accepted sample.
  - When meas_cnt reaches NUM_MEAS: delay ← ref_val, valid ← 1, → IDLE.
  - Otherwise → WAIT_EARLY.
- start while busy is ignored.
- valid and the error flags are mutually exclusive and are all cleared only by an accepted start or by rst.
- Widths:
  - skew_cnt and ref_val are DELAY_WIDTH bits.
  - meas_cnt is $clog2(NUM_MEAS+1) bits.
  - No counter can wrap, because the timeout is checked before any increment past MAX_DELAY.

## Timing
- All outputs are registered.
- Reset values: delay=0, valid=0, busy=0, err_timeout=0, err_mismatch=0; state=IDLE.
- start sampled at cycle t → busy=1 and valid=0 at t+1. mark_early is first accepted at t+1.
- Skew definition: mark_early at cycle e and mark_late at cycle e+k (0 ≤ k ≤ MAX_DELAY) give sample k.
- Final matching mark_late at cycle L → delay and valid updated and busy=0 at L+1.
- Timeout:
  - With mark_early at e and no mark_late through e+MAX_DELAY, err_timeout=1 and busy=0 at e+MAX_DELAY+1.
  - For MAX_DELAY=0 this is at e+1.
- Mismatch: mismatching mark_late at cycle L → err_mismatch=1 and busy=0 at L+1.
- Back-to-back runs: start accepted in the cycle immediately after busy falls.
- rst mid-run: next cycle is IDLE with all outputs at reset values. The previous `delay` is lost and reset to 0.
- Markers arriving in IDLE have no effect.

## Test plan
- Reset: rst high 2 cycles mid-COUNT → delay=0, valid=0, busy=0, both errors 0 on the cycle after rst.
- Nominal, MAX_DELAY=15, NUM_MEAS=4: start, then 4 pairs with mark_late 7 cycles after mark_early → delay=7, valid=1 one cycle after the 4th mark_late, busy=0.
- Zero skew: 4 pairs with simultaneous mark_early/mark_late → delay=0, valid=1. Chain to a delay line instance and check `out` equals the late channel.
- Timeout: start, mark_early, no mark_late for 16 cycles → err_timeout=1 at e+16, valid=0, delay keeps the previous value (7).
- Mismatch: samples 5,5,6 → err_mismatch=1 one cycle after the third mark_late, valid=0. A new start clears err_mismatch and busy rises.
- Edge values: skew exactly 15 → delay=15, valid=1. Stray mark_late in WAIT_EARLY and extra mark_early in COUNT have no effect. start while busy is ignored (meas_cnt is not cleared).

Source files
------------

// File: rtl/delay_skew_meas.sv
// Measures marker skew between two channels and publishes it once NUM_MEAS runs agree.
// All outputs registered; result appears the cycle after the final mark_late; start while busy is dropped.
module delay_skew_meas #(
    parameter int MAX_DELAY = 15,
    parameter int NUM_MEAS = 4,
    localparam int DELAY_WIDTH = (MAX_DELAY > 0) ? $clog2(MAX_DELAY + 1) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mark_early,
    input  logic                   mark_late,
    output logic [DELAY_WIDTH-1:0] delay,
    output logic                   valid,
    output logic                   busy,
    output logic                   err_timeout,
    output logic                   err_mismatch
);
    localparam int MW = $clog2(NUM_MEAS + 1);
    localparam logic [DELAY_WIDTH-1:0] MAX_CNT = DELAY_WIDTH'(MAX_DELAY);
    localparam logic [MW-1:0] LAST_CNT = MW'(NUM_MEAS - 1);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_EARLY = 2'd1;
    localparam logic [1:0] COUNT      = 2'd2;

    logic [1:0]             state;
    logic [DELAY_WIDTH-1:0] skew_cnt;
    logic [DELAY_WIDTH-1:0] ref_val;
    logic [MW-1:0]          meas_cnt;
    logic                   rec_vld;
    logic [DELAY_WIDTH-1:0] sample;
    logic                   mismatch;

    // A sample is either a coincident marker pair or the late marker closing a count.
    always_comb begin
        rec_vld = 1'b0;
        sample  = skew_cnt;
        if (state == WAIT_EARLY && mark_early && mark_late) begin
            rec_vld = 1'b1;
            sample  = '0;
        end else if (state == COUNT && mark_late) begin
            rec_vld = 1'b1;
        end
    end

    assign mismatch = (meas_cnt != '0) && (sample != ref_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            delay        <= '0;
            valid        <= 1'b0;
            err_timeout  <= 1'b0;
            err_mismatch <= 1'b0;
            skew_cnt     <= '0;
            ref_val      <= '0;
            meas_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= WAIT_EARLY;
                        busy         <= 1'b1;
                        meas_cnt     <= '0;
                        valid        <= 1'b0;
                        err_timeout  <= 1'b0;
                        err_mismatch <= 1'b0;
                    end
                end
                WAIT_EARLY: begin
                    if (mark_early && !mark_late) begin
                        if (MAX_DELAY == 0) begin
                            err_timeout <= 1'b1;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end else begin
                            skew_cnt <= DELAY_WIDTH'(1);
                            state    <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (!mark_late) begin
                        if (skew_cnt == MAX_CNT) begin
                            err_timeout <= 1'b1;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end else begin
                            skew_cnt <= skew_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (rec_vld) begin
                if (mismatch) begin
                    err_mismatch <= 1'b1;
                    state        <= IDLE;
                    busy         <= 1'b0;
                end else begin
                    meas_cnt <= meas_cnt + 1'b1;
                    if (meas_cnt == '0)
                        ref_val <= sample;
                    if (meas_cnt == LAST_CNT) begin
                        delay <= sample;
                        valid <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= WAIT_EARLY;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_delay_skew_meas.sv
// Randomized bench for delay_skew_meas against a per-run outcome model.
module tb_delay_skew_meas;
    localparam int MAXD = 15;
    localparam int NM   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mark_early = 1'b0;
    logic       mark_late = 1'b0;
    logic [3:0] delay;
    logic       valid;
    logic       busy;
    logic       err_timeout;
    logic       err_mismatch;

    int total = 0;
    int bad = 0;
    int model_delay = 0;
    int sk[8];

    delay_skew_meas #(.MAX_DELAY(MAXD), .NUM_MEAS(NM)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .mark_early(mark_early),
        .mark_late(mark_late),
        .delay(delay),
        .valid(valid),
        .busy(busy),
        .err_timeout(err_timeout),
        .err_mismatch(err_mismatch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sk(input int a, input int b, input int c, input int d);
        sk[0] = a; sk[1] = b; sk[2] = c; sk[3] = d;
        for (int i = 4; i < 8; i++) sk[i] = a;
    endtask

    task automatic check_idle_outputs(input string tag, input int kind);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_valid"}, int'(valid), (kind == 0) ? 1 : 0);
        check({tag, "_err_timeout"}, int'(err_timeout), (kind == 1) ? 1 : 0);
        check({tag, "_err_mismatch"}, int'(err_mismatch), (kind == 2) ? 1 : 0);
        check({tag, "_delay"}, int'(delay), model_delay);
    endtask

    // Outcome of a run follows from the list of skews alone:
    // kind 0 = published, 1 = timeout, 2 = mismatch.
    task automatic run(input string tag, input bit strays);
        int kind;
        int used;
        bit done;
        kind = 0;
        used = NM;
        done = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (!done) begin
                if (sk[i] > MAXD) begin
                    kind = 1; used = i + 1; done = 1'b1;
                end else if (i > 0 && sk[i] != sk[0]) begin
                    kind = 2; used = i + 1; done = 1'b1;
                end
            end
        end
        if (kind == 0) model_delay = sk[0];

        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_start_busy"}, int'(busy), 1);
        check({tag, "_start_valid"}, int'(valid), 0);
        check({tag, "_start_err"}, int'(err_timeout | err_mismatch), 0);

        for (int i = 0; i < used; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (strays && gap == 0) gap = 1;
            for (int g = 0; g < gap; g++) begin
                if (strays && g == 0) begin
                    mark_late = 1'b1;
                    start = 1'b1;
                end
                step();
                mark_late = 1'b0;
                start = 1'b0;
                check({tag, "_gap_busy"}, int'(busy), 1);
            end
            mark_early = 1'b1;
            if (sk[i] == 0) mark_late = 1'b1;
            step();
            mark_early = 1'b0;
            mark_late = 1'b0;
            if (sk[i] > MAXD) begin
                for (int c = 1; c < MAXD; c++) begin
                    step();
                    check({tag, "_count_busy"}, int'(busy), 1);
                end
                step();
            end else if (sk[i] > 0) begin
                for (int c = 1; c < sk[i]; c++) begin
                    if (strays && c == 1) mark_early = 1'b1;
                    step();
                    mark_early = 1'b0;
                end
                mark_late = 1'b1;
                step();
                mark_late = 1'b0;
            end
            if (i < used - 1) check({tag, "_meas_busy"}, int'(busy), 1);
        end
        check_idle_outputs(tag, kind);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        check_idle_outputs("por", 3);

        set_sk(7, 7, 7, 7);
        run("nominal7", 1'b0);
        set_sk(16, 0, 0, 0);
        run("timeout", 1'b0);
        set_sk(5, 5, 6, 5);
        run("mismatch", 1'b0);
        set_sk(0, 0, 0, 0);
        run("zero", 1'b0);
        set_sk(15, 15, 15, 15);
        run("max15", 1'b1);
        set_sk(3, 3, 3, 3);
        run("strays", 1'b1);

        mark_early = 1'b1;
        mark_late = 1'b1;
        step();
        mark_early = 1'b0;
        mark_late = 1'b0;
        step();
        check("idle_markers_busy", int'(busy), 0);
        check("idle_markers_valid", int'(valid), 1);
        check("idle_markers_delay", int'(delay), model_delay);

        // Reset in the middle of a count.
        start = 1'b1;
        step();
        start = 1'b0;
        mark_early = 1'b1;
        step();
        mark_early = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        model_delay = 0;
        check_idle_outputs("midrst", 3);
        step();
        rst = 1'b0;
        check_idle_outputs("midrst2", 3);

        for (int r = 0; r < 40; r++) begin
            int base;
            base = $urandom_range(0, MAXD);
            for (int i = 0; i < 8; i++) begin
                int sel;
                sel = $urandom_range(0, 9);
                if (sel == 0) sk[i] = MAXD + 1;
                else if (sel == 1) sk[i] = base ^ 1;
                else sk[i] = base;
            end
            run($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
